node_stream_tx: RTL

//  Reads one frame of packed node coordinates (as driven by core nodes_x/nodes_y buses)
//  and transmits it one node per valid/ready beat toward the display/host side.

---
 rtl/node_stream_tx.sv | 102 ++++++++++
 1 files changed

// File: rtl/node_stream_tx.sv
// rtl/node_stream_tx.sv - snapshot a frame of packed node coordinates and stream it one node per beat
module node_stream_tx #(
  parameter int NODE_COUNT = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic [NODE_COUNT*32-1:0]   nodes_x,
  input  logic [NODE_COUNT*32-1:0]   nodes_y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_x,
  output logic [31:0]                out_y,
  output logic [7:0]                 out_index,
  output logic                       out_last,
  output logic                       busy,
  output logic                       frame_dropped,
  output logic [15:0]                drop_count
);

  localparam logic       S_IDLE   = 1'b0;
  localparam logic       S_SEND   = 1'b1;
  localparam logic [7:0] LAST_IDX = 8'(NODE_COUNT - 1);

  logic                     r_state;
  logic [7:0]               r_idx;
  logic [NODE_COUNT*32-1:0] r_snap_x;
  logic [NODE_COUNT*32-1:0] r_snap_y;
  logic                     r_dropped;
  logic [15:0]              r_drop_count;

  logic        w_hs;
  logic        w_final;
  logic [31:0] w_x;
  logic [31:0] w_y;

  assign w_hs    = (r_state == S_SEND) && out_ready;
  assign w_final = w_hs && (r_idx == LAST_IDX);

  always_comb begin
    w_x = 32'd0;
    w_y = 32'd0;
    for (int i = 0; i < NODE_COUNT; i++) begin
      if (r_idx == 8'(i)) begin
        w_x = r_snap_x[i*32 +: 32];
        w_y = r_snap_y[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= 8'd0;
      r_snap_x     <= '0;
      r_snap_y     <= '0;
      r_dropped    <= 1'b0;
      r_drop_count <= 16'd0;
    end else begin
      r_dropped <= 1'b0;
      if (r_state == S_IDLE) begin
        if (frame_start) begin
          r_snap_x <= nodes_x;
          r_snap_y <= nodes_y;
          r_idx    <= 8'd0;
          r_state  <= S_SEND;
        end
      end else begin
        if (w_final) begin
          r_idx <= 8'd0;
          // a frame_start landing on the last handshake chains the next frame with no bubble
          if (frame_start) begin
            r_snap_x <= nodes_x;
            r_snap_y <= nodes_y;
          end else begin
            r_state <= S_IDLE;
          end
        end else begin
          if (w_hs) begin
            r_idx <= r_idx + 8'd1;
          end
          if (frame_start) begin
            r_dropped <= 1'b1;
            if (r_drop_count != 16'hFFFF) begin
              r_drop_count <= r_drop_count + 16'd1;
            end
          end
        end
      end
    end
  end

  assign out_valid     = (r_state == S_SEND);
  assign out_x         = w_x;
  assign out_y         = w_y;
  assign out_index     = r_idx;
  assign out_last      = out_valid && (r_idx == LAST_IDX);
  assign busy          = (r_state == S_SEND);
  assign frame_dropped = r_dropped;
  assign drop_count    = r_drop_count;

endmodule
